// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader
// Description : UART byte-stream loader: 'L' writes bytes into program RAM,
//               'G' launches the CPU and waits for halt. Optional trailing
//               checksum byte when LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       received,
    output logic [8:0] l_waddr,
    output logic [7:0] dwrite,
    output logic       write_en,
    output logic [8:0] startaddr,
    output logic       cpu_start,
    input  logic       halted,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] c_CMD_LOAD = 8'h4C;
    localparam logic [7:0] c_CMD_GO   = 8'h47;
    localparam logic [7:0] c_ESC      = 8'h1B;

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_L_AH  = 4'd1;
    localparam logic [3:0] c_L_AL  = 4'd2;
    localparam logic [3:0] c_L_LEN = 4'd3;
    localparam logic [3:0] c_DATA  = 4'd4;
    localparam logic [3:0] c_G_AH  = 4'd5;
    localparam logic [3:0] c_G_AL  = 4'd6;
    localparam logic [3:0] c_RUN   = 4'd7;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [3:0] c_CSUM  = 4'd8;
`endif

    logic [3:0] r_state;
    logic [8:0] r_addr;
    logic [8:0] r_count;
    logic [8:0] r_waddr;
    logic [7:0] r_dwrite;
    logic       r_wen;
    logic [8:0] r_startaddr;
    logic       r_cpu_start;
    logic       r_busy;
    logic       r_done;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_err;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_addr      <= 9'd0;
            r_count     <= 9'd0;
            r_waddr     <= 9'd0;
            r_dwrite    <= 8'd0;
            r_wen       <= 1'b0;
            r_startaddr <= 9'd0;
            r_cpu_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= 8'd0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_wen       <= 1'b0;
            r_cpu_start <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (received) begin
                        if (rx_byte == c_CMD_LOAD) begin
                            r_state <= c_L_AH;
`ifdef LOADER_CHECKSUM_EN
                            r_err   <= 1'b0;
`endif
                        end else if (rx_byte == c_CMD_GO) begin
                            r_state <= c_G_AH;
`ifdef LOADER_CHECKSUM_EN
                            r_err   <= 1'b0;
`endif
                        end
                    end
                end
                c_L_AH: begin
                    if (received) begin
                        r_addr[8] <= rx_byte[0];
                        r_state   <= c_L_AL;
                    end
                end
                c_L_AL: begin
                    if (received) begin
                        r_addr[7:0] <= rx_byte;
                        r_state     <= c_L_LEN;
                    end
                end
                c_L_LEN: begin
                    if (received) begin
                        // A length byte of zero encodes a full 256-byte block
                        r_count <= {(rx_byte == 8'd0), rx_byte};
`ifdef LOADER_CHECKSUM_EN
                        r_sum   <= 8'd0;
`endif
                        r_state <= c_DATA;
                    end
                end
                c_DATA: begin
                    if (received) begin
                        r_waddr  <= r_addr;
                        r_dwrite <= rx_byte;
                        r_wen    <= 1'b1;
                        r_addr   <= r_addr + 9'd1;
                        r_count  <= r_count - 9'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_sum    <= r_sum + rx_byte;
                        if (r_count == 9'd1) begin
                            r_state <= c_CSUM;
                        end
`else
                        if (r_count == 9'd1) begin
                            r_state <= c_IDLE;
                            r_done  <= 1'b1;
                        end
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                c_CSUM: begin
                    if (received) begin
                        r_done  <= 1'b1;
                        r_err   <= (rx_byte != r_sum);
                        r_state <= c_IDLE;
                    end
                end
`endif
                c_G_AH: begin
                    if (received) begin
                        r_addr[8] <= rx_byte[0];
                        r_state   <= c_G_AL;
                    end
                end
                c_G_AL: begin
                    if (received) begin
                        r_startaddr <= {r_addr[8], rx_byte};
                        r_cpu_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= c_RUN;
                    end
                end
                c_RUN: begin
                    // halted has priority; any byte arriving alongside it is dropped
                    if (halted || (received && (rx_byte == c_ESC))) begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign l_waddr   = r_waddr;
    assign dwrite    = r_dwrite;
    assign write_en  = r_wen;
    assign startaddr = r_startaddr;
    assign cpu_start = r_cpu_start;
    assign busy      = r_busy;
    assign done      = r_done;
`ifdef LOADER_CHECKSUM_EN
    assign err       = r_err;
`else
    assign err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_loader
// Description : Scoreboard bench for uart_loader; directed command streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       received = 1'b0;
    logic       halted = 1'b0;
    logic [8:0] l_waddr;
    logic [7:0] dwrite;
    logic       write_en;
    logic [8:0] startaddr;
    logic       cpu_start;
    logic       busy;
    logic       done;
    logic       err;

    uart_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .received  (received),
        .l_waddr   (l_waddr),
        .dwrite    (dwrite),
        .write_en  (write_en),
        .startaddr (startaddr),
        .cpu_start (cpu_start),
        .halted    (halted),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct { logic [8:0] a; logic [7:0] d; int c; } wr_t;
    typedef struct { logic e; int c; } dn_t;
    typedef struct { logic [8:0] a; int c; } st_t;
    wr_t q_wr[$];
    dn_t q_dn[$];
    st_t q_st[$];

    logic [7:0] dbuf [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Monitor: every output pulse must match the head of its queue
    always @(posedge clk) begin
        wr_t w;
        dn_t dn;
        st_t st;
        #1;
        if (write_en === 1'b1) begin
            if (q_wr.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                w = q_wr.pop_front();
                chk("waddr", 32'(l_waddr), 32'(w.a));
                chk("wdata", 32'(dwrite), 32'(w.d));
                chk("wcycle", cyc, w.c);
            end
        end
        if (done === 1'b1) begin
            if (q_dn.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                dn = q_dn.pop_front();
                chk("done_err", 32'(err), 32'(dn.e));
                chk("done_cycle", cyc, dn.c);
            end
        end
        if (cpu_start === 1'b1) begin
            if (q_st.size() == 0) begin
                chk("unexpected_start", 32'd1, 32'd0);
            end else begin
                st = q_st.pop_front();
                chk("startaddr", 32'(startaddr), 32'(st.a));
                chk("start_cycle", cyc, st.c);
                chk("start_busy", 32'(busy), 32'd1);
            end
        end
    end

    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        received = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            received = 1'b0;
        end
    endtask

    task automatic load(input logic [7:0] hi, input logic [7:0] lo, input int n,
                        input bit b2b, input bit bad);
        logic [8:0] a;
        a = {hi[0], lo};
        strobe(8'h4C);
        strobe(hi);
        strobe(lo);
        strobe(n == 256 ? 8'h00 : 8'(n));
        for (int i = 0; i < n; i++) begin
            strobe(dbuf[i]);
            q_wr.push_back('{a, dbuf[i], cyc + 1});
`ifndef LOADER_CHECKSUM_EN
            if (i == n - 1) q_dn.push_back('{bad, cyc + 1});
`endif
            a = a + 9'd1;
            if (!b2b) gap(1);
        end
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] s;
            s = 8'd0;
            for (int i = 0; i < n; i++) s = s + dbuf[i];
            strobe(bad ? s + 8'd1 : s);
            q_dn.push_back('{bad, cyc + 1});
        end
`endif
        gap(1);
    endtask

    task automatic launch(input logic [7:0] hi, input logic [7:0] lo);
        strobe(8'h47);
        strobe(hi);
        strobe(lo);
        q_st.push_back('{{hi[0], lo}, cyc + 1});
        gap(1);
        chk("busy_after_launch", 32'(busy), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_waddr", 32'(l_waddr), 32'd0);
        chk("rst_dwrite", 32'(dwrite), 32'd0);
        chk("rst_wen", 32'(write_en), 32'd0);
        chk("rst_startaddr", 32'(startaddr), 32'd0);
        chk("rst_cpu_start", 32'(cpu_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        gap(2);

        // Non-command bytes in IDLE are ignored
        strobe(8'h55); strobe(8'h00); gap(2);

        dbuf[0] = 8'hAA; dbuf[1] = 8'hBB; dbuf[2] = 8'hCC;
        load(8'h00, 8'h10, 3, 1'b0, 1'b0);
        gap(2);

        dbuf[0] = 8'h11; dbuf[1] = 8'h22;
        load(8'hFF, 8'hFF, 2, 1'b1, 1'b0);
        gap(2);

        launch(8'h01, 8'h20);
        strobe(8'h4C); strobe(8'h00); strobe(8'h10); strobe(8'h01); strobe(8'h5A);
        gap(2);
        chk("busy_run_hold", 32'(busy), 32'd1);
        @(negedge clk); halted = 1'b1;
        @(negedge clk); halted = 1'b0;
        chk("busy_after_halt", 32'(busy), 32'd0);
        chk("startaddr_hold", 32'(startaddr), 32'h120);

        dbuf[0] = 8'h77;
        load(8'h00, 8'h05, 1, 1'b0, 1'b0);
        gap(2);

        launch(8'h00, 8'h33);
        strobe(8'h1B); gap(1);
        chk("busy_after_esc", 32'(busy), 32'd0);

        launch(8'h01, 8'h00);
        @(negedge clk); halted = 1'b1; rx_byte = 8'h4C; received = 1'b1;
        @(negedge clk); halted = 1'b0; received = 1'b0;
        chk("busy_halt_wins", 32'(busy), 32'd0);

        // Reset in the middle of a data phase
        dbuf[0] = 8'h01; dbuf[1] = 8'h02;
        strobe(8'h4C); strobe(8'h00); strobe(8'h80); strobe(8'h04);
        strobe(dbuf[0]); q_wr.push_back('{9'h080, dbuf[0], cyc + 1});
        strobe(dbuf[1]); q_wr.push_back('{9'h081, dbuf[1], cyc + 1});
        @(negedge clk); received = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_wen", 32'(write_en), 32'd0);
        chk("arst_waddr", 32'(l_waddr), 32'd0);
        chk("arst_dwrite", 32'(dwrite), 32'd0);
        chk("arst_startaddr", 32'(startaddr), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        strobe(8'h03); strobe(8'h04); gap(2);
        dbuf[0] = 8'h66;
        load(8'h00, 8'h80, 1, 1'b0, 1'b0);
        gap(2);

        for (int i = 0; i < 256; i++) dbuf[i] = 8'(i) ^ 8'h5A;
        load(8'h00, 8'h00, 256, 1'b1, 1'b0);
        gap(2);
        chk("b2b_final_addr", 32'(l_waddr), 32'h0FF);

`ifdef LOADER_CHECKSUM_EN
        dbuf[0] = 8'h10; dbuf[1] = 8'h20;
        load(8'h00, 8'h00, 2, 1'b0, 1'b0);
        gap(2);
        chk("csum_ok_err", 32'(err), 32'd0);
        load(8'h00, 8'h00, 2, 1'b0, 1'b1);
        gap(2);
        chk("csum_bad_sticky", 32'(err), 32'd1);
        launch(8'h00, 8'h00);
        chk("err_cleared_by_g", 32'(err), 32'd0);
        @(negedge clk); halted = 1'b1;
        @(negedge clk); halted = 1'b0;
`else
        chk("err_tied_low", 32'(err), 32'd0);
`endif

        gap(5);
        chk("pending_writes", q_wr.size(), 32'd0);
        chk("pending_done", q_dn.size(), 32'd0);
        chk("pending_start", q_st.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_loader.md
# uart_loader

Host-side program loader sitting between the UART receiver and the CPU's program RAM write port. It parses a small byte-stream command protocol that loads bytes into RAM and launches the CPU at a given start address. It then waits for the CPU to halt before accepting further commands. It is the writer/launcher counterpart of the CPU, which reads RAM and emits bytes over the UART transmitter.

## Interface
Parameters:
- none (RAM address width fixed at 9, data width at 8)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- rx_byte  input  8  byte from UART receiver, valid when `received` is high
- received  input  1  one-cycle strobe, new byte on `rx_byte`
- l_waddr  output  9  RAM write address
- dwrite  output  8  RAM write data
- write_en  output  1  one-cycle RAM write strobe
- startaddr  output  9  CPU start address, held stable
- cpu_start  output  1  one-cycle launch pulse to the CPU start input
- halted  input  1  one-cycle pulse from the CPU when it executes HLT
- busy  output  1  high while the CPU runs a launched program
- done  output  1  one-cycle pulse when a load completes
- err  output  1  sticky error flag

## Operation
- Commands, one byte each on `received` strobes:
  - 'L' (0x4C): followed by addr_hi, addr_lo, len, then data bytes.
  - 'G' (0x47): followed by addr_hi, addr_lo.
- Only bit 0 of addr_hi is used; bits 7:1 are ignored. Address = {addr_hi[0], addr_lo}.
- `len` = 0 means 256 data bytes; otherwise `len` bytes.
- States:
  - IDLE: on 'L' → L_AH; on 'G' → G_AH; any other byte ignored, stay IDLE.
  - L_AH → L_AL → L_LEN → DATA: each transition advances on one strobe.
  - DATA: each strobe writes the byte at the current address, then increments the address. The address wraps 511 → 0.
  - After the last byte: → CSUM if the checksum feature is compiled in, else → IDLE with `done`.
  - G_AH → G_AL: the strobe in G_AL loads `startaddr`, pulses `cpu_start` and moves to RUN.
  - RUN: `busy` = 1. A `halted` pulse → IDLE. A received 0x1B (ESC) → IDLE (abandons waiting only; the CPU is unaffected). All other bytes are dropped.
- `err` clears on acceptance of an 'L' or 'G' command byte in IDLE and is set only by checksum mismatch.
- If `halted` and `received` are both high in RUN, `halted` wins and the byte is dropped.
- Reset mid-operation aborts any command immediately. The partially loaded RAM contents are not undone.

## Timing
- Reset values: l_waddr = 0, dwrite = 0, write_en = 0, startaddr = 0, cpu_start = 0, busy = 0, done = 0, err = 0, state = IDLE.
- Data write: `write_en`, `l_waddr` and `dwrite` are registered and valid in the cycle after the `received` strobe. `write_en` is high for exactly one cycle.
- `received` strobes may arrive back-to-back on consecutive cycles; every byte is accepted. There is no back-pressure.
- `done` pulses in the cycle after the strobe that completes the load (last data byte, or checksum byte).
- `cpu_start` is high for one cycle, in the cycle after the G_AL strobe. `startaddr` is updated in the same cycle and holds until the next 'G'.
- `busy` rises with `cpu_start` and falls in the cycle after `halted` or ESC.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the data bytes, one extra byte is expected, equal to the 8-bit modulo-256 sum of the data bytes.
  - On mismatch, `err` is set in the same cycle as `done`.
  - The data remains written.
- LOADER_CHECKSUM_EN undefined:
  - There is no CSUM state; `done` follows the last data byte.
  - `err` is tied to 0.

## Test plan
- Load: 4C 00 10 03 AA BB CC → writes AA@0x010, BB@0x011, CC@0x012, each one-cycle `write_en`; `done` one cycle after CC.
- Wrap: 4C 01 FF 02 11 22 → 11@0x1FF, 22@0x000; addr_hi 0xFF behaves identically to 0x01.
- Launch: 47 01 20 → `startaddr` = 0x120, one-cycle `cpu_start`, `busy` = 1. Byte 4C is then ignored. `halted` pulse → `busy` = 0 next cycle; a subsequent 'L' command is accepted.
- Abort and reset: in RUN, send 0x1B → IDLE, `busy` = 0. Assert `rst` low during DATA → all outputs return to reset values asynchronously, state = IDLE.
- Checksum (LOADER_CHECKSUM_EN): 4C 00 00 02 10 20 30 → `done`, `err` = 0. The same load with checksum byte 31 → `done`, `err` = 1. The next 'G' clears `err`.
- Back-to-back: a 256-byte load (len = 00) with strobes on consecutive cycles → 256 writes, none dropped, final address 0x0FF when starting at 0x000.
